// File: rtl/menu_pkg.sv
// Shared definitions for the title-menu controller: FSM encoding,
// menu geometry and pipeline depth.
package menu_pkg;

    typedef enum logic [1:0] {
        SEL_SINGLE = 2'd0,
        SEL_MULTI  = 2'd1,
        RUN        = 2'd2
    } menu_state_t;

    localparam logic [3:0] MENU_ROW_SINGLE = 4'd0;
    localparam logic [3:0] MENU_ROW_MULTI  = 4'd6;
    localparam logic [3:0] MENU_LAST_COL   = 4'd12;

    localparam int unsigned PIPE_LAT = 4;

endpackage

// File: rtl/menu_ctrl_btn_edge.sv
// Button conditioner: multi-flop synchronizer followed by a rising-edge
// detector, so a press of any length yields a single-cycle strobe.
module btn_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync[0] <= btn;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/menu_ctrl.sv
// Title menu: renders a 16x16 character text box with the selected entry
// highlighted, and runs the single/multi player selection FSM.
module menu_ctrl
    import menu_pkg::*;
#(
    parameter logic [10:0] TEXT_X0     = 11'd256,
    parameter logic [10:0] TEXT_Y0     = 11'd192,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_start,
    input  logic        game_over,
    output logic [7:0]  char_xy,
    input  logic [6:0]  code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_row,
    output logic        pix_on,
    output logic        hsync_d,
    output logic        vsync_d,
    output logic        hblnk_d,
    output logic        vblnk_d,
    output logic        mode_multi,
    output logic        game_start,
    output logic        start_pulse
);

    logic up_e, down_e, start_e;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_up    (.clk(clk), .rst_n(rst_n), .btn(btn_up),    .rise(up_e));
    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_down  (.clk(clk), .rst_n(rst_n), .btn(btn_down),  .rise(down_e));
    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (.clk(clk), .rst_n(rst_n), .btn(btn_start), .rise(start_e));

    menu_state_t state, state_nx;
    logic        in_menu, sel_now, enter_run, hl_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEL_SINGLE;
        else        state <= state_nx;
    end

    // Start outranks up/down; simultaneous up+down cancel each other.
    always_comb begin
        state_nx = state;
        case (state)
            SEL_SINGLE: begin
                if (start_e)               state_nx = RUN;
                else if (down_e && !up_e)  state_nx = SEL_MULTI;
            end
            SEL_MULTI: begin
                if (start_e)               state_nx = RUN;
                else if (up_e && !down_e)  state_nx = SEL_SINGLE;
            end
            RUN: begin
                if (game_over)             state_nx = mode_multi ? SEL_MULTI : SEL_SINGLE;
            end
            default:                       state_nx = SEL_SINGLE;
        endcase
    end

    always_comb begin
        in_menu    = (state != RUN);
        game_start = (state == RUN);
        sel_now    = (state == SEL_MULTI) || ((state == RUN) && mode_multi);
        enter_run  = (state != RUN) && (state_nx == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pulse <= 1'b0;
            mode_multi  <= 1'b0;
            hl_sel      <= 1'b0;
        end else begin
            start_pulse <= enter_run;
            if (enter_run) mode_multi <= (state == SEL_MULTI);
            if ((hcount == '0) && (vcount == '0)) hl_sel <= sel_now;
        end
    end

    // Text pixel pipeline: char ROM address, font ROM address, font data, pixel.
    logic [6:0] dx;
    logic [7:0] dy;
    logic       in_box;
    logic       in1, in2, in3, hl2, hl3;
    logic [2:0] col1, col2, col3;
    logic [3:0] line1;
    logic [3:0] hl_row;

    assign dx     = 7'(hcount - TEXT_X0);
    assign dy     = 8'(vcount - TEXT_Y0);
    assign in_box = ({1'b0, hcount} >= {1'b0, TEXT_X0}) &&
                    ({1'b0, hcount} <  ({1'b0, TEXT_X0} + 12'd128)) &&
                    ({1'b0, vcount} >= {1'b0, TEXT_Y0}) &&
                    ({1'b0, vcount} <  ({1'b0, TEXT_Y0} + 12'd256));
    assign hl_row = hl_sel ? MENU_ROW_MULTI : MENU_ROW_SINGLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy   <= '0;
            in1       <= 1'b0;
            col1      <= '0;
            line1     <= '0;
            font_addr <= '0;
            in2       <= 1'b0;
            col2      <= '0;
            hl2       <= 1'b0;
            in3       <= 1'b0;
            col3      <= '0;
            hl3       <= 1'b0;
            pix_on    <= 1'b0;
        end else begin
            char_xy   <= {dy[7:4], dx[6:3]};
            in1       <= in_box;
            col1      <= dx[2:0];
            line1     <= dy[3:0];
            font_addr <= {code, line1};
            in2       <= in1;
            col2      <= col1;
            hl2       <= in_menu && (char_xy[7:4] == hl_row) && (char_xy[3:0] <= MENU_LAST_COL);
            in3       <= in2;
            col3      <= col2;
            hl3       <= hl2;
            pix_on    <= in3 & (font_row[3'd7 - col3] ^ hl3);
        end
    end

    logic [PIPE_LAT-1:0][3:0] strb_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) strb_pipe <= '0;
        else        strb_pipe <= {strb_pipe[PIPE_LAT-2:0], {hsync, vsync, hblnk, vblnk}};
    end

    assign {hsync_d, vsync_d, hblnk_d, vblnk_d} = strb_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_menu_ctrl.sv
// Bench for menu_ctrl: behavioural ROMs, an arithmetic pixel model and an
// event-level selection model, with directed and randomized steps.
module tb_menu_ctrl;

    localparam logic [10:0] X0 = 11'd256;
    localparam logic [10:0] Y0 = 11'd192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk;
    logic        btn_up, btn_down, btn_start, game_over;
    logic [7:0]  char_xy;
    logic [6:0]  code;
    logic [10:0] font_addr;
    logic [7:0]  font_row;
    logic        pix_on, hsync_d, vsync_d, hblnk_d, vblnk_d;
    logic        mode_multi, game_start, start_pulse;

    menu_ctrl #(.TEXT_X0(X0), .TEXT_Y0(Y0), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
        .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
        .game_over(game_over), .char_xy(char_xy), .code(code),
        .font_addr(font_addr), .font_row(font_row), .pix_on(pix_on),
        .hsync_d(hsync_d), .vsync_d(vsync_d), .hblnk_d(hblnk_d), .vblnk_d(vblnk_d),
        .mode_multi(mode_multi), .game_start(game_start), .start_pulse(start_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] rom_code(input logic [7:0] xy);
        return xy[6:0] ^ {xy[7], 6'h15};
    endfunction

    function automatic logic [7:0] rom_font(input logic [10:0] a);
        logic [31:0] h;
        h = a * 32'd2654435761;
        return h[23:16] ^ h[7:0];
    endfunction

    assign code = rom_code(char_xy);
    always @(posedge clk) font_row <= rom_font(font_addr);

    int checks = 0;
    int errors = 0;
    int m_sel, m_run, m_mode, m_hl;

    typedef struct {
        logic       pix;
        logic [3:0] strb;
    } exp_t;
    exp_t q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic exp_pix(input int h, input int v);
        int dx, dy, row, col, line, px;
        logic [7:0] f;
        logic       hl;
        if (h < X0 || h >= X0 + 128 || v < Y0 || v >= Y0 + 256) return 1'b0;
        dx = h - X0;  dy = v - Y0;
        row = dy / 16; col = dx / 8; line = dy % 16; px = dx % 8;
        f  = rom_font({rom_code(8'(row * 16 + col)), 4'(line)});
        hl = (m_run == 0) && (row == (m_hl ? 6 : 0)) && (col <= 12);
        return f[7 - px] ^ hl;
    endfunction

    task automatic idle_px();
        hcount = 11'd2000; vcount = 11'd2000;
        {hsync, vsync, hblnk, vblnk} = 4'b0000;
    endtask

    task automatic frame_start();
        hcount = '0; vcount = '0;
        tick();
        m_hl = m_run ? m_mode : m_sel;
        idle_px();
        tick();
    endtask

    task automatic scan(input int n);
        exp_t e;
        int h, v;
        for (int i = 0; i < n + 4; i++) begin
            tick();
            if (q.size() == 4) begin
                e = q.pop_front();
                chk("pix_on", pix_on, e.pix);
                chk("strobes_d", {hsync_d, vsync_d, hblnk_d, vblnk_d}, e.strb);
            end
            if (i < n) begin
                h = X0 - 8 + $urandom_range(0, 143);
                v = ($urandom_range(0, 1) == 0) ? (Y0 - 8 + $urandom_range(0, 271))
                                                : (Y0 + $urandom_range(0, 127));
                hcount = 11'(h); vcount = 11'(v);
                {hsync, vsync, hblnk, vblnk} = 4'($urandom);
            end else begin
                idle_px();
                h = 2000; v = 2000;
            end
            e.pix  = exp_pix(h, v);
            e.strb = {hsync, vsync, hblnk, vblnk};
            q.push_back(e);
        end
        q.delete();
        idle_px();
    endtask

    task automatic press(input logic u, input logic d, input logic s, input int hold);
        int sp;
        int entered;
        sp = 0;
        entered = 0;
        btn_up = u; btn_down = d; btn_start = s;
        for (int i = 0; i < hold; i++) begin
            tick();
            sp += int'(start_pulse);
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            sp += int'(start_pulse);
        end
        if (m_run == 0) begin
            if (s) begin
                m_run = 1; m_mode = m_sel; entered = 1;
            end else if (u && !d) m_sel = 0;
            else if (d && !u)     m_sel = 1;
        end
        chk("start_pulse_count", sp, entered);
        chk("game_start", game_start, m_run);
        chk("mode_multi", mode_multi, m_mode);
    endtask

    task automatic end_game();
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        if (m_run != 0) begin
            m_run = 0; m_sel = m_mode;
        end
        tick();
        chk("game_start_after_over", game_start, m_run);
        chk("mode_multi_after_over", mode_multi, m_mode);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_on"},      pix_on, 0);
        chk({tag, "_strobes"},     {hsync_d, vsync_d, hblnk_d, vblnk_d}, 0);
        chk({tag, "_game_start"},  game_start, 0);
        chk({tag, "_start_pulse"}, start_pulse, 0);
        chk({tag, "_mode_multi"},  mode_multi, 0);
        chk({tag, "_char_xy"},     char_xy, 0);
        chk({tag, "_font_addr"},   font_addr, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0; game_over = 1'b0;
        idle_px();
        m_sel = 0; m_run = 0; m_mode = 0; m_hl = 0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        hcount = X0; vcount = Y0;
        tick();
        chk("char_xy_origin", char_xy, 8'h00);
        hcount = X0 + 11'd43; vcount = Y0 + 11'd98;
        tick();
        chk("char_xy_r6c5", char_xy, 8'h65);
        chk("font_addr_origin", font_addr, {rom_code(8'h00), 4'd0});
        idle_px();
        tick();
        chk("font_addr_r6c5", font_addr, {rom_code(8'h65), 4'd2});

        frame_start();
        scan(400);

        // Selection moves at once, highlight only from the next frame start.
        press(1'b0, 1'b1, 1'b0, 3);
        scan(200);
        frame_start();
        scan(200);

        press(1'b1, 1'b0, 1'b0, 3);
        frame_start();
        press(1'b1, 1'b1, 1'b0, 3);
        frame_start();
        scan(150);

        press(1'b0, 1'b1, 1'b0, 3);
        press(1'b0, 1'b0, 1'b1, 3);
        press(1'b1, 1'b0, 1'b0, 3);
        press(1'b0, 1'b1, 1'b0, 3);
        frame_start();
        scan(100);
        end_game();
        frame_start();
        scan(150);

        end_game();
        scan(80);

        press(1'b0, 1'b0, 1'b1, 1000);
        end_game();
        press(1'b1, 1'b0, 1'b0, 1000);
        frame_start();
        scan(150);

        press(1'b0, 1'b1, 1'b0, 2);
        press(1'b0, 1'b0, 1'b1, 2);
        press(1'b1, 1'b0, 1'b1, 2);
        end_game();
        press(1'b0, 1'b1, 1'b1, 2);
        end_game();
        frame_start();
        scan(100);

        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 7))
                0: press(1'b1, 1'b0, 1'b0, $urandom_range(2, 6));
                1: press(1'b0, 1'b1, 1'b0, $urandom_range(2, 6));
                2: press(1'b1, 1'b1, 1'b0, $urandom_range(2, 6));
                3: press(1'b0, 1'b0, 1'b1, $urandom_range(2, 6));
                4: press(1'b1, 1'b0, 1'b1, $urandom_range(2, 6));
                5: press(1'b0, 1'b1, 1'b1, $urandom_range(2, 6));
                6: end_game();
                default: press(1'b0, 1'b1, 1'b0, 50);
            endcase
            frame_start();
            scan(80);
        end

        if (m_run == 0) press(1'b0, 1'b0, 1'b1, 3);
        frame_start();
        hcount = X0 + 11'd5; vcount = Y0 + 11'd3;
        repeat ($urandom_range(1, 20)) tick();
        #($urandom_range(1, 6));
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        idle_px();
        repeat (2) tick();
        rst_n = 1'b1;
        m_sel = 0; m_run = 0; m_mode = 0; m_hl = 0;
        scan(100);
        press(1'b0, 1'b1, 1'b0, 3);
        press(1'b0, 1'b0, 1'b1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/menu_ctrl.md
MENU_CTRL -- requirements
Module: menu_ctrl

Interface
REQ-001 SHALL have parameter TEXT_X0, default 11'd256: left pixel of the 16x16-character text box.
REQ-002 SHALL have parameter TEXT_Y0, default 11'd192: top pixel of the text box.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: button synchronizer depth.
REQ-004 clk  in  1  single system/pixel clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 hcount, vcount  in  11 each  current pixel position.
REQ-007 hsync, vsync, hblnk, vblnk  in  1 each  timing strobes, delayed alongside pixels.
REQ-008 btn_up, btn_down, btn_start  in  1 each  raw asynchronous buttons, active-high.
REQ-009 game_over  in  1  single-cycle pulse that returns the block to the menu.
REQ-010 char_xy  out  8  character ROM address {row[3:0], col[3:0]}.
REQ-011 code  in  7  character ROM data; combinational from char_xy.
REQ-012 font_addr  out  11  font ROM address {code, line[3:0]}.
REQ-013 font_row  in  8  font ROM data; 1-cycle synchronous read; bit 7 is the leftmost pixel.
REQ-014 pix_on  out  1  text pixel, after highlight inversion.
REQ-015 hsync_d, vsync_d, hblnk_d, vblnk_d  out  1 each  timing strobes delayed 4 cycles.
REQ-016 mode_multi  out  1  committed selection: 0 = single player, 1 = multi player.
REQ-017 game_start  out  1  level, high while a game runs.
REQ-018 start_pulse  out  1  one-cycle pulse on entry to RUN.

Function
REQ-019 Pipeline:
- c1: register char_xy = {(vcount-TEXT_Y0)[7:4], (hcount-TEXT_X0)[6:3]} and register in_box.
- c2: register font_addr = {code, (vcount-TEXT_Y0)[3:0]}; also register pixel column [2:0].
- c3: font_row valid.
- c4: register pix_on.
REQ-020 Total hcount-to-pix_on latency SHALL be exactly 4 cycles; all *_d strobes SHALL carry the same latency.
REQ-021 in_box SHALL be true only when TEXT_X0 <= hcount < TEXT_X0+128 and TEXT_Y0 <= vcount < TEXT_Y0+256; outside the box, pix_on = 0.
REQ-022 pix_on SHALL equal font_row[7-col] XOR hl, where hl = 1 only when all of the following hold:
- state is a menu state;
- char row = (hl_sel ? 6 : 0);
- char col <= 12.
REQ-023 Buttons SHALL pass through a SYNC_STAGES flop synchronizer, then a rising-edge detect; each press acts exactly once.
REQ-024 FSM states: SEL_SINGLE, SEL_MULTI, RUN.
- SEL_SINGLE: down-edge -> SEL_MULTI.
- SEL_MULTI: up-edge -> SEL_SINGLE.
- Either menu state: start-edge -> RUN.
- RUN: game_over -> the menu state matching mode_multi.
REQ-025 Simultaneous up and down edges SHALL be ignored; a start edge in the same cycle as up/down SHALL win and commit the pre-cycle selection.
REQ-026 On entry to RUN, mode_multi SHALL be latched and start_pulse asserted for one cycle; game_start SHALL be high throughout RUN.
REQ-027 In RUN, button edges SHALL be ignored and mode_multi held.
REQ-028 hl_sel SHALL copy the FSM selection only when hcount==0 and vcount==0 (frame start), so no frame tears.
REQ-029 A game_over pulse outside RUN SHALL have no effect.

Reset
REQ-030 While rst_n is low, SHALL force:
- state = SEL_SINGLE; hl_sel = 0; mode_multi = 0;
- game_start, start_pulse, pix_on, all *_d = 0;
- char_xy = 0; font_addr = 0; synchronizer and edge flops = 0.
REQ-031 Reset mid-frame or mid-game SHALL abort immediately; the first valid pixel is produced 4 cycles after release.

Structure
REQ-032 Shared package menu_pkg SHALL hold:
- the FSM state encoding;
- MENU_ROW_SINGLE = 4'd0, MENU_ROW_MULTI = 4'd6, MENU_LAST_COL = 4'd12;
- PIPE_LAT = 4.
REQ-033 The synchronizer plus edge detector SHALL be one sub-module, btn_edge, instantiated three times.
REQ-034 The character ROM and font ROM SHALL be external; this block only addresses them.

Verification
REQ-035 Reset, then scan frame with behavioral ROMs -> char_xy = 8'h00 at (256,192) one cycle later; row 0 inverted, row 6 normal; pix_on latency = 4.
REQ-036 Down press mid-frame -> state = SEL_MULTI next cycle+sync; highlight moves to row 6 only from the next frame start.
REQ-037 Up and down asserted the same cycle in SEL_SINGLE -> state unchanged, no highlight change.
REQ-038 Start in SEL_MULTI -> start_pulse one cycle, game_start = 1, mode_multi = 1; further buttons ignored; game_over -> SEL_MULTI, game_start = 0.
REQ-039 Button held 1000 cycles -> exactly one transition.
REQ-040 rst_n low during RUN at arbitrary cycle -> all outputs 0 asynchronously; state = SEL_SINGLE after release.
